// File: rtl/hpdcache_rsp_sched.sv
// hpdcache_rsp_sched: per-bank response FIFOs merged onto one core response port by a round-robin arbiter
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   bank_rsp_valid_i/_i    per-bank response valid and payload
//   bank_rsp_stall_o       per-bank "do not present a new response" (FIFO nearly full)
//   core_rsp_valid_o/_o    merged response to the requester, core_rsp_ready_i accepts it
//   overflow_o             sticky flag: a response was dropped because its FIFO was full
module hpdcache_rsp_sched #(
    parameter int NBANKS    = 2,
    parameter int DEPTH     = 4,
    parameter int RSP_WIDTH = 64
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NBANKS-1:0]                bank_rsp_valid_i,
    input  logic [NBANKS-1:0][RSP_WIDTH-1:0] bank_rsp_i,
    output logic [NBANKS-1:0]                bank_rsp_stall_o,
    output logic                             core_rsp_valid_o,
    input  logic                             core_rsp_ready_i,
    output logic [RSP_WIDTH-1:0]             core_rsp_o,
    output logic                             overflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(NBANKS);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e               state_q, state_d;
    logic [RW-1:0]        rr_q, rr_d, lock_q, lock_d, gnt_free, gnt, idx;
    logic [PW-1:0]        wptr_q [NBANKS];
    logic [PW-1:0]        rptr_q [NBANKS];
    logic [CW-1:0]        cnt_q  [NBANKS];
    logic [RSP_WIDTH-1:0] mem_q  [NBANKS][DEPTH];
    logic [NBANKS-1:0]    nonempty, push, pop;
    logic                 found, hs, ovf_q;

    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            nonempty[b]         = cnt_q[b] != '0;
            bank_rsp_stall_o[b] = cnt_q[b] >= CW'(DEPTH - 1);
        end
    end

    // first non-empty FIFO starting from rr
    always_comb begin
        gnt_free = rr_q;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < NBANKS; i++) begin
            idx = RW'((int'(rr_q) + i) % NBANKS);
            if (!found && nonempty[idx]) begin
                found    = 1'b1;
                gnt_free = idx;
            end
        end
    end

    // once a response is shown without acceptance the grant is frozen so the payload stays stable
    assign gnt              = (state_q == LOCKED) ? lock_q : gnt_free;
    assign core_rsp_valid_o = (|nonempty) || (state_q == LOCKED);
    assign hs               = core_rsp_valid_o && core_rsp_ready_i;
    assign core_rsp_o       = mem_q[gnt][rptr_q[gnt]];
    assign overflow_o       = ovf_q;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        if (hs) begin
            state_d = IDLE;
            rr_d    = (gnt == RW'(NBANKS - 1)) ? '0 : gnt + RW'(1);
        end else if (core_rsp_valid_o) begin
            state_d = LOCKED;
            lock_d  = gnt;
        end
    end

    // a full FIFO still accepts a write when it pops in the same cycle
    always_comb begin
        for (int b = 0; b < NBANKS; b++) begin
            pop[b]  = hs && (gnt == RW'(b));
            push[b] = bank_rsp_valid_i[b] && ((cnt_q[b] != CW'(DEPTH)) || pop[b]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
            ovf_q   <= 1'b0;
            for (int b = 0; b < NBANKS; b++) begin
                wptr_q[b] <= '0;
                rptr_q[b] <= '0;
                cnt_q[b]  <= '0;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
            ovf_q   <= ovf_q | (|(bank_rsp_valid_i & ~push));
            for (int b = 0; b < NBANKS; b++) begin
                if (push[b]) wptr_q[b] <= (wptr_q[b] == PW'(DEPTH - 1)) ? '0 : wptr_q[b] + PW'(1);
                if (pop[b])  rptr_q[b] <= (rptr_q[b] == PW'(DEPTH - 1)) ? '0 : rptr_q[b] + PW'(1);
                cnt_q[b] <= cnt_q[b] + CW'(push[b]) - CW'(pop[b]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NBANKS; b++) begin
            if (push[b]) mem_q[b][wptr_q[b]] <= bank_rsp_i[b];
        end
    end
endmodule
